// File: rtl/adxl355_pkg.sv
// ADXL355 reader shared definitions: register map, frame lengths, FSM states.
// Imported by the frame engine and the reader top.
package adxl355_pkg;

  localparam logic [7:0] REG_XDATA3    = 8'h08;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;

  localparam logic [6:0] INIT_BITS = 7'd16;
  localparam logic [6:0] READ_BITS = 7'd80;

  typedef enum logic [1:0] {
    INIT,
    GAP,
    IDLE,
    READ
  } state_t;

  // ADXL355 command byte: 7-bit address then R/W in the LSB.
  function automatic logic [7:0] cmd_byte(
    input logic [7:0] addr,
    input logic       rw
  );
    return (addr << 1) | {7'd0, rw};
  endfunction

endpackage

// File: rtl/spi_frame_master.sv
// Generic SPI mode-0 frame engine: one csn-low frame of nbits bits.
// Ports: start/nbits/tx in; csn/sclk/mosi pins; rx_bit+rx_valid stream; done; active.
module spi_frame_master
  import adxl355_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [6:0]  nbits,
  input  logic [15:0] tx,
  input  logic        miso,
  output logic        csn,
  output logic        sclk,
  output logic        mosi,
  output logic        rx_bit,
  output logic        rx_valid,
  output logic        done,
  output logic        active
);

  logic [7:0]  div_cnt;
  logic [7:0]  edge_cnt;
  logic [6:0]  len;
  logic [15:0] shreg;
  logic        tick;
  logic        last;

  // Even edge numbers raise sclk, odd ones lower it; edge 2n ends the frame.
  assign tick     = active && (div_cnt == 8'(CLK_DIV - 1));
  assign last     = (edge_cnt == {len, 1'b0});
  assign done     = tick && last;
  assign rx_valid = tick && !last && !edge_cnt[0];
  assign rx_bit   = miso;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active   <= 1'b0;
      csn      <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      len      <= '0;
      shreg    <= '0;
    end else if (!active) begin
      if (start) begin
        active   <= 1'b1;
        csn      <= 1'b0;
        mosi     <= tx[15];
        shreg    <= {tx[14:0], 1'b0};
        div_cnt  <= '0;
        edge_cnt <= '0;
        len      <= nbits;
      end
    end else if (tick) begin
      div_cnt  <= '0;
      edge_cnt <= edge_cnt + 8'd1;
      if (last) begin
        active <= 1'b0;
        csn    <= 1'b1;
        sclk   <= 1'b0;
        mosi   <= 1'b0;
      end else if (!edge_cnt[0]) begin
        sclk <= 1'b1;
      end else begin
        sclk  <= 1'b0;
        mosi  <= shreg[15];
        shreg <= {shreg[14:0], 1'b0};
      end
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/adxl355_spi_reader.sv
// ADXL355 SPI master: enables measurement, then burst-reads XYZ on DRDY.
// Ports: clk/rstn/enable/drdy/miso in; csn/sclk/mosi, x/y/z+valid, overrun, busy out.
module adxl355_spi_reader
  import adxl355_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CSN_GAP = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        drdy,
  input  logic        miso,
  output logic        csn,
  output logic        sclk,
  output logic        mosi,
  output logic [19:0] x,
  output logic [19:0] y,
  output logic [19:0] z,
  output logic        valid,
  output logic        overrun,
  output logic        busy
);

  localparam logic [15:0] INIT_TX =
    {cmd_byte(REG_POWER_CTL, CMD_WRITE), 8'h00};
  localparam logic [15:0] READ_TX =
    {cmd_byte(REG_XDATA3, CMD_READ), 8'h00};

  state_t      state;
  state_t      nxt;
  logic        start;
  logic        start_read;
  logic        go;
  logic        fm_done;
  logic        fm_active;
  logic        fm_rx_bit;
  logic        fm_rx_valid;
  logic [6:0]  fm_nbits;
  logic [15:0] fm_tx;
  logic [15:0] gap_cnt;
  logic [71:0] rx_sh;
  logic        drdy_s1;
  logic        drdy_s2;
  logic        drdy_s3;
  logic        rise;
  logic        pending;

  assign fm_nbits = (state == INIT) ? INIT_BITS : READ_BITS;
  assign fm_tx    = (state == INIT) ? INIT_TX : READ_TX;

  spi_frame_master #(
    .CLK_DIV(CLK_DIV)
  ) u_fm (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .nbits   (fm_nbits),
    .tx      (fm_tx),
    .miso    (miso),
    .csn     (csn),
    .sclk    (sclk),
    .mosi    (mosi),
    .rx_bit  (fm_rx_bit),
    .rx_valid(fm_rx_valid),
    .done    (fm_done),
    .active  (fm_active)
  );

  assign rise       = drdy_s2 & ~drdy_s3;
  assign go         = pending & enable;
  assign start_read = start & (state != INIT);
  assign busy       = ~csn | (state == GAP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= INIT;
    end else begin
      state <= nxt;
    end
  end

  // The last GAP cycle may launch the next READ so that csn stays
  // high for exactly CSN_GAP cycles between back-to-back frames.
  always_comb begin
    nxt   = state;
    start = 1'b0;
    unique case (state)
      INIT: begin
        start = ~fm_active;
        if (fm_done) nxt = GAP;
      end
      GAP: begin
        if (gap_cnt == '0) begin
          if (go) begin
            start = 1'b1;
            nxt   = READ;
          end else begin
            nxt = IDLE;
          end
        end
      end
      IDLE: begin
        if (go) begin
          start = 1'b1;
          nxt   = READ;
        end
      end
      READ: begin
        if (fm_done) nxt = GAP;
      end
      default: nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drdy_s1 <= 1'b0;
      drdy_s2 <= 1'b0;
      drdy_s3 <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      drdy_s1 <= drdy;
      drdy_s2 <= drdy_s1;
      drdy_s3 <= drdy_s2;
      if (start_read) begin
        pending <= rise;
      end else if (rise) begin
        pending <= 1'b1;
      end
      if (rise && pending) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gap_cnt <= '0;
    end else if (fm_done) begin
      gap_cnt <= 16'(CSN_GAP - 1);
    end else if (state == GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 16'd1;
    end
  end

  // The command byte also shifts through; it falls off the top.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_sh <= '0;
      valid <= 1'b0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
    end else begin
      if (fm_rx_valid) begin
        rx_sh <= {rx_sh[70:0], fm_rx_bit};
      end
      valid <= fm_done && (state == READ);
      if (fm_done && state == READ) begin
        x <= rx_sh[71:52];
        y <= rx_sh[47:28];
        z <= rx_sh[23:4];
      end
    end
  end

endmodule

// File: tb/tb_adxl355_spi_reader.sv
// Self-checking bench: two readers (slow/fast SPI) with ADXL355 slave models.
// Frames, command bytes, samples and handshakes are checked against a model.
module tb_adxl355_spi_reader;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b1;
  logic        drdy = 1'b0;
  logic        csn_a   [2];
  logic        sclk_a  [2];
  logic        mosi_a  [2];
  logic        miso_a  [2];
  logic        valid_a [2];
  logic        ovr_a   [2];
  logic        busy_a  [2];
  logic [19:0] x_a     [2];
  logic [19:0] y_a     [2];
  logic [19:0] z_a     [2];

  int checks = 0;
  int passes = 0;

  logic [71:0] cur_data = '0;
  logic [79:0] resp    [2];
  logic [79:0] mosi_sh [2];
  int  idx      [2];
  int  bitcnt   [2];
  int  lowcnt   [2];
  int  hicnt    [2];
  int  last_gap [2];
  int  last_len [2];
  int  reads    [2];
  int  inits    [2];
  bit  expect_init [2];
  bit  prev_csn  [2];
  bit  prev_sclk [2];
  bit  exp_ovr = 1'b0;
  bit  rend;

  always #20 clk = ~clk;

  adxl355_spi_reader #(.CLK_DIV(2), .CSN_GAP(4)) u_slow (
    .clk(clk), .rstn(rstn), .enable(enable), .drdy(drdy),
    .miso(miso_a[0]), .csn(csn_a[0]), .sclk(sclk_a[0]),
    .mosi(mosi_a[0]), .x(x_a[0]), .y(y_a[0]), .z(z_a[0]),
    .valid(valid_a[0]), .overrun(ovr_a[0]), .busy(busy_a[0])
  );

  adxl355_spi_reader #(.CLK_DIV(1), .CSN_GAP(1)) u_fast (
    .clk(clk), .rstn(rstn), .enable(enable), .drdy(drdy),
    .miso(miso_a[1]), .csn(csn_a[1]), .sclk(sclk_a[1]),
    .mosi(mosi_a[1]), .x(x_a[1]), .y(y_a[1]), .z(z_a[1]),
    .valid(valid_a[1]), .overrun(ovr_a[1]), .busy(busy_a[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_miso
    assign miso_a[g] = (!csn_a[g] && idx[g] < 80) ?
                       resp[g][79 - idx[g]] : 1'b0;
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Sample for axis a: {b[3a], b[3a+1], upper nibble of b[3a+2]}.
  function automatic logic [19:0] model_axis(
    input logic [71:0] d, input int a);
    int b [3];
    for (int k = 0; k < 3; k++) begin
      b[k] = int'((d >> (8 * (8 - (3 * a + k)))) & 72'hFF);
    end
    return 20'(b[0] * 4096 + b[1] * 16 + b[2] / 16);
  endfunction

  task automatic chk(input string name, input int i,
                     input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s[%0d]: got %h expected %h", name, i, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        lowcnt[i]    = 0;
        hicnt[i]     = 0;
        prev_csn[i]  = 1'b1;
        prev_sclk[i] = 1'b0;
      end else begin
        rend = 1'b0;
        if (prev_csn[i] && !csn_a[i]) begin
          resp[i]     = {8'h00, cur_data};
          idx[i]      = 0;
          bitcnt[i]   = 0;
          mosi_sh[i]  = '0;
          last_gap[i] = hicnt[i];
        end
        if (!csn_a[i] && !prev_sclk[i] && sclk_a[i]) begin
          mosi_sh[i] = {mosi_sh[i][78:0], mosi_a[i]};
          bitcnt[i]++;
        end
        if (!csn_a[i] && prev_sclk[i] && !sclk_a[i]) idx[i]++;
        if (!csn_a[i]) begin
          lowcnt[i]++;
        end else begin
          chk("sclk_idle", i, sclk_a[i], 0);
          hicnt[i]++;
          if (lowcnt[i] > 0) begin
            last_len[i] = lowcnt[i];
            chk("csn_low_len", i, lowcnt[i],
                (2 * bitcnt[i] + 1) * div_of(i));
            if (bitcnt[i] == 16) begin
              chk("init_expected", i, expect_init[i], 1);
              chk("init_mosi", i, mosi_sh[i][15:0], 16'h5A00);
              expect_init[i] = 1'b0;
              inits[i]++;
            end else begin
              rend = 1'b1;
              chk("frame_bits", i, bitcnt[i], 80);
              chk("init_first", i, expect_init[i], 0);
              chk("read_mosi", i, mosi_sh[i], {8'h11, 72'h0});
              chk("x", i, x_a[i], model_axis(resp[i][71:0], 0));
              chk("y", i, y_a[i], model_axis(resp[i][71:0], 1));
              chk("z", i, z_a[i], model_axis(resp[i][71:0], 2));
              chk("overrun", i, ovr_a[i], exp_ovr);
              reads[i]++;
            end
            lowcnt[i] = 0;
            hicnt[i]  = 1;
          end
        end
        chk("valid", i, valid_a[i], rend);
        prev_csn[i]  = csn_a[i];
        prev_sclk[i] = sclk_a[i];
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_drdy();
    drdy = 1'b1;
    cyc(3);
    drdy = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy_a[0] || busy_a[1]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 0, n < budget, 1);
  endtask

  task automatic check_reset_outputs(input int i);
    chk("rst_csn", i, csn_a[i], 1);
    chk("rst_sclk", i, sclk_a[i], 0);
    chk("rst_mosi", i, mosi_a[i], 0);
    chk("rst_x", i, x_a[i], 0);
    chk("rst_y", i, y_a[i], 0);
    chk("rst_z", i, z_a[i], 0);
    chk("rst_valid", i, valid_a[i], 0);
    chk("rst_overrun", i, ovr_a[i], 0);
    chk("rst_busy", i, busy_a[i], 0);
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int rb [2];
    int ib [2];
    for (int i = 0; i < 2; i++) begin
      reads[i] = 0;
      inits[i] = 0;
      idx[i] = 0;
      bitcnt[i] = 0;
      lowcnt[i] = 0;
      hicnt[i] = 0;
      last_gap[i] = 0;
      last_len[i] = 0;
      resp[i] = '0;
      mosi_sh[i] = '0;
      expect_init[i] = 1'b1;
    end

    cyc(3);
    for (int i = 0; i < 2; i++) check_reset_outputs(i);
    rstn = 1'b1;
    cyc(10);
    wait_idle(500);
    for (int i = 0; i < 2; i++) begin
      chk("init_count", i, inits[i], 1);
      chk("idle_csn", i, csn_a[i], 1);
      chk("idle_valid", i, valid_a[i], 0);
    end
    chk("init_len_lit", 0, last_len[0], 66);
    chk("init_len_lit", 1, last_len[1], 33);

    // Known sample set and DRDY-to-csn latency.
    cur_data = 72'h12_34_56_78_9A_BC_F0_00_0F;
    drdy = 1'b1;
    n = 0;
    while (csn_a[0] && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 3) drdy = 1'b0;
    end
    drdy = 1'b0;
    chk("drdy_latency", 0, n, 4);
    chk("drdy_latency", 1, csn_a[1], 0);
    cyc(10);
    wait_idle(1000);
    for (int i = 0; i < 2; i++) begin
      chk("x_lit", i, x_a[i], 20'h12345);
      chk("y_lit", i, y_a[i], 20'h789AB);
      chk("z_lit", i, z_a[i], 20'hF0000);
      chk("z_negative", i, $signed(z_a[i]) < 0, 1);
      chk("read_count", i, reads[i], 1);
    end
    chk("read_len_lit", 0, last_len[0], 322);
    chk("read_len_lit", 1, last_len[1], 161);

    // Random samples with asynchronous DRDY phase.
    for (int k = 0; k < 6; k++) begin
      cur_data = {$urandom(), $urandom(), 8'($urandom())};
      #($urandom_range(1, 39));
      drdy = 1'b1;
      #(40 * 3);
      drdy = 1'b0;
      @(negedge clk);
      cyc(10);
      wait_idle(1000);
      cyc($urandom_range(0, 20));
    end
    for (int i = 0; i < 2; i++) begin
      chk("random_reads", i, reads[i], 7);
      chk("no_overrun", i, ovr_a[i], 0);
    end

    // enable low holds the pending edge.
    for (int i = 0; i < 2; i++) rb[i] = reads[i];
    cur_data = {$urandom(), $urandom(), 8'($urandom())};
    enable = 1'b0;
    pulse_drdy();
    cyc(100);
    for (int i = 0; i < 2; i++) begin
      chk("enable_block", i, reads[i], rb[i]);
      chk("enable_csn", i, csn_a[i], 1);
    end
    enable = 1'b1;
    n = 0;
    while (csn_a[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("enable_latency", 0, n <= 2, 1);
    chk("enable_latency", 1, csn_a[1], 0);
    cyc(10);
    wait_idle(1000);
    for (int i = 0; i < 2; i++) chk("enable_read", i, reads[i], rb[i] + 1);

    // Three edges inside one READ: one follow-up frame, sticky overrun.
    for (int i = 0; i < 2; i++) rb[i] = reads[i];
    cur_data = {$urandom(), $urandom(), 8'($urandom())};
    pulse_drdy();
    n = 0;
    while (csn_a[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ovr_start", 0, n < 20, 1);
    cyc(20);
    pulse_drdy();
    cyc(17);
    pulse_drdy();
    cyc(17);
    pulse_drdy();
    cyc(10);
    exp_ovr = 1'b1;
    cyc(10);
    wait_idle(2000);
    cyc(50);
    for (int i = 0; i < 2; i++) begin
      chk("ovr_reads", i, reads[i] - rb[i], 2);
      chk("b2b_gap", i, last_gap[i], gap_of(i));
      chk("ovr_sticky", i, ovr_a[i], 1);
    end

    // Asynchronous reset in the middle of a READ.
    cur_data = {$urandom(), $urandom(), 8'($urandom())};
    pulse_drdy();
    n = 0;
    while (bitcnt[0] < 40 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("mid_wait", 0, n < 500, 1);
    #5 rstn = 1'b0;
    #1;
    check_reset_outputs(0);
    chk("rst_csn", 1, csn_a[1], 1);
    chk("rst_overrun", 1, ovr_a[1], 0);
    exp_ovr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_init[i] = 1'b1;
      rb[i] = reads[i];
      ib[i] = inits[i];
    end
    @(negedge clk);
    cyc(3);
    rstn = 1'b1;
    cyc(2);
    cur_data = {$urandom(), $urandom(), 8'($urandom())};
    pulse_drdy();
    cyc(10);
    wait_idle(2000);
    for (int i = 0; i < 2; i++) begin
      chk("reinit", i, inits[i], ib[i] + 1);
      chk("post_rst_read", i, reads[i], rb[i] + 1);
      chk("post_rst_ovr", i, ovr_a[i], 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
